// File: rtl/latched_ram_ctrl.sv
// Word-addressed RAM with a req/ack handshake and a fixed multi-cycle access latency.
// Requests are captured in IDLE, performed after ACCESS_CYCLES edges, and acknowledged in DONE.
module latched_ram_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  capture;
  logic                  do_access;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state, counter and datapath strobes
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_n   = CNT_W'(ACCESS_CYCLES - 1);
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          do_access = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Request capture, memory array and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (capture) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (do_access) begin
        if (we_q) begin
          mem[addr_q] <= wdata_q;
        end else begin
          rdata <= mem[addr_q];
        end
      end
      ack  <= (state_n == DONE);
      busy <= (state_n != IDLE);
    end
  end

endmodule
